// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
//  - load_store_funct3_t : load/store size encodings carried on req_funct3
//  - write_back_t        : {data, valid} response returned to the core
//  - dmem_state_t        : responder FSM states
//  - is_legal_ls()       : funct3/direction/alignment legality (range is checked by the top)
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        F3_BYTE       = 3'b000,
        F3_HALFWORD   = 3'b001,
        F3_WORD       = 3'b010,
        F3_BYTE_U     = 3'b100,
        F3_HALFWORD_U = 3'b101
    } load_store_funct3_t;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } write_back_t;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_BUSY,
        DMEM_RESP
    } dmem_state_t;

    // Unsigned variants exist only for loads; a store has nothing to extend.
    function automatic logic is_legal_ls(input logic       write,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        case (funct3)
            F3_BYTE:       return 1'b1;
            F3_HALFWORD:   return ~addr_lo[0];
            F3_WORD:       return addr_lo == 2'b00;
            F3_BYTE_U:     return ~write;
            F3_HALFWORD_U: return ~write & ~addr_lo[0];
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and write-back response bundle between core LSU and responder.
//  master (core side) : drives req_valid/req_write/req_addr/req_funct3/req_wdata, rsp_ready
//  slave  (responder) : drives req_ready, wb {data, valid}, rsp_err
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    write_back_t wb;
    logic        rsp_err;
    logic        rsp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, wb, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, wb, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for one 32-bit RAM word.
//  funct3     in  access size / signedness
//  lane       in  byte offset within the word (addr[1:0])
//  rdata      in  RAM word being loaded from
//  wdata      in  right-justified store data
//  load_data  out extracted and sign/zero-extended load result
//  byte_en    out per-byte write enables for a store
//  store_data out store data moved up to its lane
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{lane, 3'b000} +: 8];
        // Halfwords are 2-byte aligned, so only lane[1] picks the half.
        half_sel   = lane[1] ? rdata[31:16] : rdata[15:0];
        store_data = wdata << {lane, 3'b000};
        load_data  = rdata;
        byte_en    = 4'b0000;
        case (funct3)
            F3_BYTE: begin
                load_data = {{24{byte_sel[7]}}, byte_sel};
                byte_en   = 4'b0001 << lane;
            end
            F3_HALFWORD: begin
                load_data = {{16{half_sel[15]}}, half_sel};
                byte_en   = 4'b0011 << lane;
            end
            F3_WORD: begin
                load_data = rdata;
                byte_en   = 4'b1111;
            end
            F3_BYTE_U:     load_data = {24'h0, byte_sel};
            F3_HALFWORD_U: load_data = {16'h0, half_sel};
            default:       load_data = rdata;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one sized load/store at a time, waits LATENCY
// clocks, then presents the aligned result (or store ack) until the consumer takes it.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : dmem_responder_if.slave (request in, write_back_t/rsp_err out)
// Parameters: DEPTH_WORDS (power of 2) RAM words, LATENCY (>=1) accept-to-response clocks.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    write_back_t       wb_q, wb_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rdata, load_data, store_data;
    logic [3:0]        byte_en;
    logic              legal, mem_we;

    assign word_idx = addr_q[ADDR_W+1:2];
    assign rdata    = mem[word_idx];
    assign legal    = is_legal_ls(write_q, funct3_q, addr_q[1:0])
                    && ((addr_q >> (ADDR_W + 2)) == 32'd0);

    dmem_lane_align u_align (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .rdata      (rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_data (store_data)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        wdata_d   = wdata_q;
        wb_d      = wb_q;
        rsp_err_d = rsp_err_q;
        mem_we    = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata;
                    // Even LATENCY==1 spends its one wait clock here, so the
                    // response lands exactly LATENCY edges after acceptance.
                    cnt_d    = CNT_W'(LATENCY - 1);
                    state_d  = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                if (cnt_q == '0) begin
                    // This edge is the RESP entry: register the result and commit the store together.
                    state_d    = DMEM_RESP;
                    wb_d.valid = 1'b1;
                    wb_d.data  = (legal && !write_q) ? load_data : 32'h0;
                    rsp_err_d  = ~legal;
                    mem_we     = legal & write_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DMEM_RESP: begin
                // Returning to IDLE here means a request present this cycle is only seen next clock.
                if (bus.rsp_ready) begin
                    state_d    = DMEM_IDLE;
                    wb_d.valid = 1'b0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= 32'h0;
            funct3_q  <= 3'b000;
            wdata_q   <= 32'h0;
            wb_q      <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            wdata_q   <= wdata_d;
            wb_q      <= wb_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain block RAM; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == DMEM_IDLE);
    assign bus.wb        = wb_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one LATENCY=1 and one LATENCY=3 instance,
// directed requests, a byte-addressed reference memory and a per-cycle compare process.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int NEVER = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    logic [1:0]       drv_valid, drv_write, drv_rrdy;
    logic [1:0][2:0]  drv_f3;
    logic [1:0][31:0] drv_addr, drv_wdata;
    logic [1:0]       obs_ready, obs_valid, obs_err;
    logic [1:0][31:0] obs_data;

    assign bus_a.req_valid  = drv_valid[0];
    assign bus_a.req_write  = drv_write[0];
    assign bus_a.req_addr   = drv_addr[0];
    assign bus_a.req_funct3 = drv_f3[0];
    assign bus_a.req_wdata  = drv_wdata[0];
    assign bus_a.rsp_ready  = drv_rrdy[0];
    assign bus_b.req_valid  = drv_valid[1];
    assign bus_b.req_write  = drv_write[1];
    assign bus_b.req_addr   = drv_addr[1];
    assign bus_b.req_funct3 = drv_f3[1];
    assign bus_b.req_wdata  = drv_wdata[1];
    assign bus_b.rsp_ready  = drv_rrdy[1];

    assign obs_ready[0] = bus_a.req_ready;
    assign obs_valid[0] = bus_a.wb.valid;
    assign obs_data[0]  = bus_a.wb.data;
    assign obs_err[0]   = bus_a.rsp_err;
    assign obs_ready[1] = bus_b.req_ready;
    assign obs_valid[1] = bus_b.wb.valid;
    assign obs_data[1]  = bus_b.wb.data;
    assign obs_err[1]   = bus_b.rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mem_b [2][DEPTH*4];
    bit          pend [2];
    int          acc [2];
    int          rel [2];
    logic [31:0] exp_data [2];
    bit          exp_err [2];
    int          edge_n = 0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    // Access size in bytes for a funct3, 0 when the code is not usable in this direction.
    function automatic int size_of(input bit wr, input logic [2:0] f3);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b100:  return wr ? 0 : 1;
            3'b101:  return wr ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic void model_access(input int d, input bit wr, input logic [2:0] f3,
                                         input logic [31:0] addr,
                                         output logic [31:0] data, output bit err);
        int size;
        logic [31:0] v;
        size = size_of(wr, f3);
        err  = 1'b0;
        if (size == 0) err = 1'b1;
        else if ((addr % size) != 0) err = 1'b1;
        else if (addr >= 32'(DEPTH * 4)) err = 1'b1;
        data = 32'h0;
        if (!err && !wr) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_b[d][int'(addr) + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            data = v;
        end
    endfunction

    function automatic void model_store(input int d, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        int size;
        logic [31:0] w;
        size = size_of(1'b1, f3);
        w    = wdata;
        for (int i = 0; i < size; i++) mem_b[d][int'(addr) + i] = w[8*i +: 8];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin : cmp
        int n;
        bit busy_now, resp_now;
        #2;
        if (rst_n && cmp_en) begin
            n = edge_n;
            for (int d = 0; d < 2; d++) begin
                busy_now = pend[d] && n >= acc[d] && n < rel[d];
                resp_now = pend[d] && n >= acc[d] + lat_of(d) && n < rel[d];
                check($sformatf("req_ready dut%0d edge%0d", d, n), 32'(obs_ready[d]), 32'(!busy_now));
                check($sformatf("wb.valid dut%0d edge%0d", d, n), 32'(obs_valid[d]), 32'(resp_now));
                if (resp_now) begin
                    check($sformatf("wb.data dut%0d edge%0d", d, n), obs_data[d], exp_data[d]);
                    check($sformatf("rsp_err dut%0d edge%0d", d, n), 32'(obs_err[d]), 32'(exp_err[d]));
                end else begin
                    check($sformatf("rsp_err idle dut%0d edge%0d", d, n), 32'(obs_err[d]), 32'h0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One full transaction; hold = extra clocks rsp_ready stays low once wb is valid.
    // While the request is outstanding the request fields are scrambled and req_valid stays high.
    task automatic issue(input int d, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input bit use_lit,
                         input logic [31:0] lit, input bit lit_err, input string name);
        logic [31:0] ed;
        bit ee;
        model_access(d, wr, f3, addr, ed, ee);
        if (use_lit) begin
            check({name, " model data"}, ed, lit);
            check({name, " model err"}, 32'(ee), 32'(lit_err));
        end
        @(negedge clk);
        drv_write[d] = wr;
        drv_f3[d]    = f3;
        drv_addr[d]  = addr;
        drv_wdata[d] = wdata;
        drv_valid[d] = 1'b1;
        exp_data[d]  = ed;
        exp_err[d]   = ee;
        acc[d]       = edge_n + 1;
        rel[d]       = NEVER;
        pend[d]      = 1'b1;
        @(negedge clk);
        drv_write[d] = ~wr;
        drv_f3[d]    = 3'b111;
        drv_addr[d]  = ~addr;
        drv_wdata[d] = ~wdata;
        while (edge_n < acc[d] + lat_of(d)) @(negedge clk);
        repeat (hold) @(negedge clk);
        if (use_lit) begin
            check({name, " wb.data"}, obs_data[d], lit);
            check({name, " rsp_err"}, 32'(obs_err[d]), 32'(lit_err));
        end
        drv_rrdy[d] = 1'b1;
        rel[d]      = edge_n + 1;
        @(negedge clk);
        drv_rrdy[d]  = 1'b0;
        drv_valid[d] = 1'b0;
        pend[d]      = 1'b0;
        if (wr && !ee) model_store(d, f3, addr, wdata);
    endtask

    task automatic check_quiet(input int d, input string name);
        check({name, " req_ready"}, 32'(obs_ready[d]), 32'h1);
        check({name, " wb.valid"}, 32'(obs_valid[d]), 32'h0);
        check({name, " wb.data"}, obs_data[d], 32'h0);
        check({name, " rsp_err"}, 32'(obs_err[d]), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        drv_valid = '0;
        drv_write = '0;
        drv_rrdy  = '0;
        drv_f3    = '0;
        drv_addr  = '0;
        drv_wdata = '0;
        foreach (mem_b[i, j]) mem_b[i][j] = 8'h00;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            acc[d]  = 0;
            rel[d]  = NEVER;
        end

        // Reset state, checked while reset is held.
        repeat (2) @(negedge clk);
        check_quiet(0, "reset dut0");
        check_quiet(1, "reset dut1");
        rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // 1) word store / load
        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0,        0, "t1 st word");
        issue(0, 0, 3'b010, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF, 0, "t1 ld word");
        // 2) sub-word loads with extension
        issue(0, 0, 3'b000, 32'h13, 32'h0, 0, 1, 32'hFFFFFFDE, 0, "t2 lb 13");
        issue(0, 0, 3'b100, 32'h13, 32'h0, 1, 1, 32'h000000DE, 0, "t2 lbu 13");
        issue(0, 0, 3'b001, 32'h12, 32'h0, 0, 1, 32'hFFFFDEAD, 0, "t2 lh 12");
        issue(0, 0, 3'b101, 32'h10, 32'h0, 2, 1, 32'h0000BEEF, 0, "t2 lhu 10");
        issue(0, 0, 3'b100, 32'h11, 32'h0, 0, 1, 32'h000000BE, 0, "t2 lbu 11");
        issue(0, 0, 3'b001, 32'h10, 32'h0, 0, 1, 32'hFFFFBEEF, 0, "t2 lh 10");
        // 3) partial stores leave other bytes intact
        issue(0, 1, 3'b000, 32'h11, 32'hCCCCCC55, 0, 1, 32'h0,        0, "t3 sb 11");
        issue(0, 0, 3'b010, 32'h10, 32'h0,        0, 1, 32'hDEAD55EF, 0, "t3 ld after sb");
        issue(0, 1, 3'b001, 32'h12, 32'hFFFF1234, 0, 1, 32'h0,        0, "t3 sh 12");
        issue(0, 0, 3'b010, 32'h10, 32'h0,        0, 1, 32'h123455EF, 0, "t3 ld after sh");
        // 4) rejected accesses
        issue(0, 0, 3'b010, 32'h12,       32'h0,        0, 1, 32'h0, 1, "t4 lw misaligned");
        issue(0, 1, 3'b001, 32'h11,       32'hFFFFFFFF, 0, 1, 32'h0, 1, "t4 sh misaligned");
        issue(0, 1, 3'b100, 32'h10,       32'hFFFFFFFF, 0, 1, 32'h0, 1, "t4 st f3=100");
        issue(0, 0, 3'b010, 32'h1000,     32'h0,        0, 1, 32'h0, 1, "t4 lw out of range");
        issue(0, 0, 3'b011, 32'h10,       32'h0,        0, 1, 32'h0, 1, "t4 ld f3=011");
        issue(0, 1, 3'b010, 32'h80000010, 32'hFFFFFFFF, 0, 1, 32'h0, 1, "t4 sw high addr");
        issue(0, 0, 3'b010, 32'h10,       32'h0,        0, 1, 32'h123455EF, 0, "t4 ram unchanged");
        // last word of the array is still in range
        issue(0, 1, 3'b010, 32'hFFC, 32'hCAFEF00D, 0, 1, 32'h0,        0, "t4 sw last");
        issue(0, 0, 3'b101, 32'hFFE, 32'h0,        0, 1, 32'h0000CAFE, 0, "t4 lhu last");

        // 5) LATENCY=3 timing, response held through back-pressure
        issue(1, 1, 3'b010, 32'h40, 32'h0BADF00D, 5, 1, 32'h0,        0, "t5 sw");
        issue(1, 0, 3'b010, 32'h40, 32'h0,        5, 1, 32'h0BADF00D, 0, "t5 lw");
        issue(1, 0, 3'b000, 32'h41, 32'h0,        0, 1, 32'hFFFFFFF0, 0, "t5 lb");

        // 6) reset during BUSY aborts a store
        issue(1, 1, 3'b010, 32'h20, 32'h11111111, 0, 1, 32'h0, 0, "t6 preload");
        @(negedge clk);
        drv_write[1] = 1'b1;
        drv_f3[1]    = 3'b010;
        drv_addr[1]  = 32'h20;
        drv_wdata[1] = 32'hAAAAAAAA;
        drv_valid[1] = 1'b1;
        exp_data[1]  = 32'h0;
        exp_err[1]   = 1'b0;
        acc[1]       = edge_n + 1;
        rel[1]       = NEVER;
        pend[1]      = 1'b1;
        @(posedge clk);
        #1;
        drv_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        pend[1] = 1'b0;
        #1;
        check_quiet(1, "t6 in reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet(1, "t6 after reset");
        issue(1, 0, 3'b010, 32'h20, 32'h0, 0, 1, 32'h11111111, 0, "t6 ld after abort");
        issue(0, 0, 3'b010, 32'h10, 32'h0, 0, 1, 32'h123455EF, 0, "t6 dut0 ram kept");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
